// File: rtl/not16_pkg.sv
// Shared definitions for the inverter checker: FSM state type and default widths.
package not16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vec_compare16.sv
// Combinational comparison of an inverter response against the bitwise inverse of its stimulus.
module vec_compare16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] vec_in,
    input  logic [WIDTH-1:0] vec_out,
    output logic             match,
    output logic [WIDTH-1:0] mismatch_mask
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign mismatch_mask[gi] = vec_out[gi] ^ ~vec_in[gi];
        end
    endgenerate

    assign match = ~|mismatch_mask;

endmodule

// File: rtl/not16_checker.sv
// Run-based checker for a 16-bit inverter: counts passing/failing vectors and records the first failure.
module not16_checker
    import not16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_in,
    input  logic [WIDTH-1:0] vec_out,
    input  logic             vec_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_mask
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] pass_reg, pass_next;
    logic [CNT_W-1:0] fail_reg, fail_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic             ffv_reg, ffv_next;
    logic [CNT_W-1:0] ffi_reg, ffi_next;
    logic [WIDTH-1:0] ffm_reg, ffm_next;

    logic             cmp_match;
    logic [WIDTH-1:0] cmp_mask;
    logic             xfer;

    vec_compare16 #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .vec_in       (vec_in),
        .vec_out      (vec_out),
        .match        (cmp_match),
        .mismatch_mask(cmp_mask)
    );

    assign vec_ready = (state_reg == RUN);
    assign xfer      = vec_ready && vec_valid;

    always_comb begin
        state_next = state_reg;
        pass_next  = pass_reg;
        fail_next  = fail_reg;
        idx_next   = idx_reg;
        ffv_next   = ffv_reg;
        ffi_next   = ffi_reg;
        ffm_next   = ffm_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    pass_next  = '0;
                    fail_next  = '0;
                    idx_next   = '0;
                    ffv_next   = 1'b0;
                    ffi_next   = '0;
                    ffm_next   = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (cmp_match) begin
                        if (pass_reg != CNT_MAX) pass_next = pass_reg + CNT_W'(1);
                    end else begin
                        if (fail_reg != CNT_MAX) fail_next = fail_reg + CNT_W'(1);
                        // Only the first failure of a run is recorded.
                        if (!ffv_reg) begin
                            ffv_next = 1'b1;
                            ffi_next = idx_reg;
                            ffm_next = cmp_mask;
                        end
                    end
                    if (idx_reg != CNT_MAX) idx_next = idx_reg + CNT_W'(1);
                    if (vec_last) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pass_reg  <= '0;
            fail_reg  <= '0;
            idx_reg   <= '0;
            ffv_reg   <= 1'b0;
            ffi_reg   <= '0;
            ffm_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pass_reg  <= pass_next;
            fail_reg  <= fail_next;
            idx_reg   <= idx_next;
            ffv_reg   <= ffv_next;
            ffi_reg   <= ffi_next;
            ffm_reg   <= ffm_next;
        end
    end

    assign busy             = (state_reg == RUN);
    assign done             = (state_reg == DONE);
    assign pass_count       = pass_reg;
    assign fail_count       = fail_reg;
    assign first_fail_valid = ffv_reg;
    assign first_fail_idx   = ffi_reg;
    assign first_fail_mask  = ffm_reg;

endmodule

// File: doc/not16_checker.md
NOT16_CHECKER -- requirements
Module: not16_checker

Interface
REQ-001 Parameter WIDTH, default 16, data width of checked vectors.
REQ-002 Parameter CNT_W, default 8, width of all counters and the index.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a check run.
REQ-006 vec_valid  input  1  producer offers a vector this cycle.
REQ-007 vec_ready  output  1  checker accepts a vector this cycle.
REQ-008 vec_in  input  WIDTH  stimulus applied to the 16-bit inverter under test.
REQ-009 vec_out  input  WIDTH  response captured from the inverter under test.
REQ-010 vec_last  input  1  marks the final vector of the run.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass_count  output  CNT_W  vectors where vec_out == ~vec_in.
REQ-014 fail_count  output  CNT_W  vectors where vec_out != ~vec_in.
REQ-015 first_fail_valid  output  1  at least one failure recorded this run.
REQ-016 first_fail_idx  output  CNT_W  zero-based index of the first failing vector.
REQ-017 first_fail_mask  output  WIDTH  vec_out XOR ~vec_in of the first failing vector.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 IDLE: vec_ready=0; start=1 SHALL clear counters, index and first-fail outputs, then go to RUN next cycle.
REQ-020 RUN: vec_ready SHALL be 1 combinationally, and a transfer SHALL occur only when vec_valid && vec_ready.
REQ-021 On a transfer, the checker SHALL increment pass_count or fail_count one cycle later (registered, latency 1).
REQ-022 On a transfer, the vector index SHALL increment after use; the first vector has index 0.
REQ-023 On the first failing transfer of a run, the checker SHALL set first_fail_valid and capture first_fail_idx and first_fail_mask; later failures SHALL NOT overwrite them.
REQ-024 A transfer with vec_last=1 SHALL be checked normally, and the FSM SHALL go to DONE on the same edge.
REQ-025 vec_last with vec_valid=0 SHALL be ignored.
REQ-026 DONE: vec_ready=0 and all result outputs SHALL be held stable; start SHALL clear results and go to RUN.
REQ-027 start asserted in RUN SHALL be ignored; the run continues.
REQ-028 pass_count, fail_count and the index SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-029 Comparison SHALL be the bitwise full-WIDTH equality vec_out == ~vec_in, with no X-propagation special cases.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, vec_ready=0, busy=0, done=0 and all counters, index, first_fail_valid, first_fail_idx and first_fail_mask to 0.
REQ-031 Reset asserted mid-RUN SHALL discard the partial run, and no transfer SHALL be counted on that edge.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start.

Structure
REQ-033 A shared package not16_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default WIDTH and CNT_W constants.
REQ-034 The design SHALL use one sub-module, vec_compare16, a combinational block outputting match and mismatch mask from vec_in/vec_out.
REQ-035 The FSM, counters and first-fail capture SHALL reside in not16_checker.

Verification
REQ-036 Reset, start, then 5 correct vectors (0000->FFFF, FFFF->0000, AAAA->5555, 3CC3->C33C, 1234->EDCB, last on 5th) -> pass=5, fail=0, first_fail_valid=0, done=1.
REQ-037 Vector 2 (AAAA) answered with 5554 -> fail=1, first_fail_idx=2, first_fail_mask=0001; a later bad vector leaves idx/mask unchanged.
REQ-038 vec_valid toggled 1/0 per cycle over 4 vectors -> counts advance only on valid cycles; latency of exactly 1 cycle checked.
REQ-039 rst_n pulsed low mid-run after 3 vectors -> all outputs 0 asynchronously, state IDLE; a new start counts from 0.
REQ-040 300 correct vectors with CNT_W=8 -> pass_count saturates at 255; start in DONE clears to 0.
REQ-041 start during RUN and vec_valid in IDLE/DONE -> no state change, no counts, vec_ready=0 outside RUN.
